seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four hex digits shown on a scanned active-low 7-segment bus and publishes one value per frame.
// Optional macro DP_CAPTURE_EN adds per-digit decimal point capture on dp_out.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clkin,
  input  logic        btnR,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        decode_err
`ifdef DP_CAPTURE_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

  // {legal, blank, nibble}
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = 6'b10_0000;
      7'b1111001: seg_decode = 6'b10_0001;
      7'b0100100: seg_decode = 6'b10_0010;
      7'b0110000: seg_decode = 6'b10_0011;
      7'b0011001: seg_decode = 6'b10_0100;
      7'b0010010: seg_decode = 6'b10_0101;
      7'b0000010: seg_decode = 6'b10_0110;
      7'b1111000: seg_decode = 6'b10_0111;
      7'b0000000: seg_decode = 6'b10_1000;
      7'b0010000: seg_decode = 6'b10_1001;
      7'b0001000: seg_decode = 6'b10_1010;
      7'b0000011: seg_decode = 6'b10_1011;
      7'b1000110: seg_decode = 6'b10_1100;
      7'b0100001: seg_decode = 6'b10_1101;
      7'b0000110: seg_decode = 6'b10_1110;
      7'b0001110: seg_decode = 6'b10_1111;
      7'b1111111: seg_decode = 6'b11_0000;
      default:    seg_decode = 6'b00_0000;
    endcase
  endfunction

  // {exactly one anode active, digit index}
  function automatic logic [2:0] an_decode(input logic [3:0] a);
    case (a)
      4'b1110: an_decode = 3'b1_00;
      4'b1101: an_decode = 3'b1_01;
      4'b1011: an_decode = 3'b1_10;
      4'b0111: an_decode = 3'b1_11;
      default: an_decode = 3'b0_00;
    endcase
  endfunction

  logic [3:0]       an_p0, an_p1;
  logic [6:0]       seg_p0, seg_p1;
  logic [CNT_W-1:0] stab_cnt;
  logic             same, sample;
  logic [5:0]       dec;
  logic [2:0]       anv;
  logic             cap_new, err_new, cap;
  logic [1:0]       cap_idx;
  logic [3:0]       cap_nib;
  logic             cap_blk;
  logic             pend_vld, pend_blk;
  logic [1:0]       pend_idx;
  logic [3:0]       pend_nib;
  logic [15:0]      shadow_nib, shadow_nib_nxt;
  logic [3:0]       shadow_blk, shadow_blk_nxt;
  logic [3:0]       seen, seen_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  state_t           state, state_nxt;
`ifdef DP_CAPTURE_EN
  logic             dp_p0, dp_p1, cap_dp, pend_dp;
  logic [3:0]       shadow_dp, shadow_dp_nxt;
`else
  logic             unused_dp;
  assign unused_dp = dp;
`endif

  // Stage p0/p1: registered input and previous copy for the stability window
  always_ff @(posedge clkin) begin
    an_p0  <= an;
    seg_p0 <= seg;
    an_p1  <= an_p0;
    seg_p1 <= seg_p0;
`ifdef DP_CAPTURE_EN
    dp_p0  <= dp;
    dp_p1  <= dp_p0;
`endif
  end

`ifdef DP_CAPTURE_EN
  assign same = (an_p0 == an_p1) && (seg_p0 == seg_p1) && (dp_p0 == dp_p1);
`else
  assign same = (an_p0 == an_p1) && (seg_p0 == seg_p1);
`endif
  assign sample = same && (stab_cnt == STABLE_PRE);

  always_ff @(posedge clkin) begin
    if (btnR)                   stab_cnt <= '0;
    else if (!same)             stab_cnt <= '0;
    else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + 1'b1;
  end

  // Classification; a capture seen during PUBLISH is parked and replayed in IDLE
  always_comb begin
    dec     = seg_decode(seg_p0);
    anv     = an_decode(an_p0);
    cap_new = sample && anv[2] && dec[5];
    err_new = sample && (an_p0 != 4'hF) && !(anv[2] && dec[5]);
    cap     = (state != PUBLISH) && (pend_vld || cap_new);
    cap_idx = pend_vld ? pend_idx : anv[1:0];
    cap_nib = pend_vld ? pend_nib : dec[3:0];
    cap_blk = pend_vld ? pend_blk : dec[4];
`ifdef DP_CAPTURE_EN
    cap_dp  = pend_vld ? pend_dp : ~dp_p0;
    shadow_dp_nxt = shadow_dp;
    if (cap) shadow_dp_nxt[cap_idx] = cap_dp;
`endif
    shadow_nib_nxt = shadow_nib;
    shadow_blk_nxt = shadow_blk;
    seen_nxt       = seen;
    if (cap) begin
      shadow_nib_nxt[{cap_idx, 2'b00} +: 4] = cap_nib;
      shadow_blk_nxt[cap_idx]               = cap_blk;
      seen_nxt[cap_idx]                     = 1'b1;
    end
  end

  assign tmo_hit = (state == COLLECT) && !cap && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap) state_nxt = (seen_nxt == 4'hF) ? PUBLISH : COLLECT;
      COLLECT: begin
        if (seen_nxt == 4'hF) state_nxt = PUBLISH;
        else if (tmo_hit)     state_nxt = IDLE;
      end
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign frame_valid = (state == PUBLISH);

  // Stage p2: frame assembly, publish and control state
  always_ff @(posedge clkin) begin
    shadow_nib <= shadow_nib_nxt;
    shadow_blk <= shadow_blk_nxt;
`ifdef DP_CAPTURE_EN
    shadow_dp  <= shadow_dp_nxt;
    if (state == PUBLISH && cap_new) pend_dp <= ~dp_p0;
`endif
    if (state == PUBLISH && cap_new) begin
      pend_idx <= anv[1:0];
      pend_nib <= dec[3:0];
      pend_blk <= dec[4];
    end
  end

  always_ff @(posedge clkin) begin
    if (btnR) begin
      state      <= IDLE;
      seen       <= '0;
      value      <= '0;
      blank      <= '0;
      decode_err <= 1'b0;
      tmo_cnt    <= '0;
      pend_vld   <= 1'b0;
`ifdef DP_CAPTURE_EN
      dp_out     <= '0;
`endif
    end else begin
      state      <= state_nxt;
      decode_err <= err_new;
      seen       <= (state_nxt == IDLE) ? 4'h0 : seen_nxt;
      pend_vld   <= (state == PUBLISH) && cap_new;
      if (cap || state != COLLECT) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + 1'b1;
      if (state_nxt == PUBLISH && state != PUBLISH) begin
        value <= shadow_nib_nxt;
        blank <= shadow_blk_nxt;
`ifdef DP_CAPTURE_EN
        dp_out <= shadow_dp_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES=4 and TIMEOUT_CYCLES=64.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        btnR;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        decode_err;
`ifdef DP_CAPTURE_EN
  logic [3:0]  dp_out;
`endif

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int fv_base, err_base;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clkin(clk),
    .btnR(btnR),
    .seg(seg),
    .an(an),
    .dp(dp),
    .value(value),
    .blank(blank),
    .frame_valid(frame_valid),
    .decode_err(decode_err)
`ifdef DP_CAPTURE_EN
    ,
    .dp_out(dp_out)
`endif
  );

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (decode_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'b1000000;  4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;  4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;  4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;  4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;  4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;  4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;  4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;  default: hex_seg = 7'b0001110;
    endcase
  endfunction

  task automatic put(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int i, input logic [3:0] h);
    logic [3:0] a;
    a = 4'b0001 << i;
    put(~a, hex_seg(h), 1'b1, 8);
  endtask

  task automatic frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) digit(i, v[4*i +: 4]);
    put(4'hF, 7'h7F, 1'b1, 8);
  endtask

  task automatic mark;
    fv_base = fv_cnt; err_base = err_cnt;
  endtask

  initial begin
    btnR = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(decode_err), 32'h0);
    btnR = 1'b0;
    put(4'hF, 7'h7F, 1'b1, 10);

    mark();
    frame(16'h1A3F);
    check("scan_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("scan_value", 32'(value), 32'h1A3F);
    check("scan_blank", 32'(blank), 32'h0);
    check("scan_err", 32'(err_cnt - err_base), 32'd0);

    mark();
    digit(0, 4'h7);
    digit(1, 4'h0);
    put(4'b1011, 7'b0000000, 1'b1, 2);
    digit(2, 4'h5);
    digit(3, 4'h0);
    put(4'hF, 7'h7F, 1'b1, 8);
    check("glitch_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("glitch_value", 32'(value), 32'h0507);
    check("glitch_err", 32'(err_cnt - err_base), 32'd0);

    mark();
    put(4'b1100, hex_seg(4'h3), 1'b1, 8);
    check("bad_an_err", 32'(err_cnt - err_base), 32'd1);
    put(4'b1110, 7'b1010101, 1'b1, 8);
    check("bad_seg_err", 32'(err_cnt - err_base), 32'd2);
    digit(1, 4'h2);
    digit(2, 4'h3);
    digit(3, 4'h4);
    check("no_d0_fv", 32'(fv_cnt - fv_base), 32'd0);
    digit(0, 4'h1);
    put(4'hF, 7'h7F, 1'b1, 8);
    check("d0_late_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("d0_late_value", 32'(value), 32'h4321);

    mark();
    digit(0, 4'h9);
    digit(1, 4'h8);
    digit(2, 4'h7);
    put(4'hF, 7'h7F, 1'b1, 80);
    check("tmo_fv", 32'(fv_cnt - fv_base), 32'd0);
    check("tmo_value", 32'(value), 32'h4321);
    digit(3, 4'h0);
    put(4'hF, 7'h7F, 1'b1, 4);
    check("tmo_seen_cleared", 32'(fv_cnt - fv_base), 32'd0);
    digit(0, 4'h0);
    digit(1, 4'h8);
    digit(2, 4'h2);
    put(4'hF, 7'h7F, 1'b1, 8);
    check("after_tmo_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("after_tmo_value", 32'(value), 32'h0280);

    mark();
    digit(0, 4'h7);
    digit(1, 4'h2);
    digit(2, 4'h0);
    put(4'b0111, 7'b1111111, 1'b1, 8);
    put(4'hF, 7'h7F, 1'b1, 8);
    check("blank_value", 32'(value), 32'h0027);
    check("blank_bits", 32'(blank), 32'h8);
    check("blank_err", 32'(err_cnt - err_base), 32'd0);

    mark();
    digit(0, 4'h5);
    digit(1, 4'h5);
    an = 4'hF; seg = 7'h7F;
    btnR = 1'b1;
    @(negedge clk);
    btnR = 1'b0;
    put(4'hF, 7'h7F, 1'b1, 4);
    check("mid_rst_value", 32'(value), 32'h0);
    check("mid_rst_blank", 32'(blank), 32'h0);
    check("mid_rst_fv", 32'(fv_cnt - fv_base), 32'd0);
    digit(0, 4'hF);
    put(4'b1101, hex_seg(4'hF), 1'b0, 8);
    digit(2, 4'hF);
    digit(3, 4'hF);
    put(4'hF, 7'h7F, 1'b1, 8);
    check("ffff_fv", 32'(fv_cnt - fv_base), 32'd1);
    check("ffff_value", 32'(value), 32'hFFFF);
`ifdef DP_CAPTURE_EN
    check("dp_out", 32'(dp_out), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
